// File: rtl/hub75_pkg.sv
// Shared HUB75 panel constants and types.
// Used by both the receiver and the matrix driver.
package hub75_pkg;

  localparam int COLS      = 64;
  localparam int ROW_BITS  = 4;
  localparam int PIX_BITS  = 6;
  localparam int COL_BITS  = 6;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int CNT_BITS  = 7;
  localparam int LC_BITS   = 16;
  localparam int BUS_W     = 1 + ROW_BITS + PIX_BITS;

  localparam logic [CNT_BITS-1:0] CNT_FULL = 7'd64;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = 7'd127;
  localparam logic [COL_BITS-1:0] COL_LAST = 6'd63;

  // hub_rgb bit positions
  localparam int RGB_R0 = 5;
  localparam int RGB_G0 = 4;
  localparam int RGB_B0 = 3;
  localparam int RGB_R1 = 2;
  localparam int RGB_G1 = 1;
  localparam int RGB_B1 = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/hub75_rx_if.sv
// Frame-memory write port: valid/ready with address and pixel pair.
// master = receiver, slave = frame memory.
interface hub75_rx_if;
  import hub75_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [PIX_BITS-1:0]  wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/hub75_edge_sync.sv
// Synchronizer plus one delay flop; rise marks a 0->1 edge that
// lines up with the delayed hub data bus.
module hub75_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 line receiver: shifts panel data, snapshots it on latch and
// dumps the line column by column into frame memory.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hub_clk,
  input  logic [PIX_BITS-1:0] hub_rgb,
  input  logic [ROW_BITS-1:0] hub_addr,
  input  logic                hub_lat,
  input  logic                hub_oe,
  hub75_rx_if.master          wr,
  output logic                line_done,
  output logic                len_err,
  output logic                overrun,
  output logic                lit,
  output logic [LC_BITS-1:0]  line_count
);

  logic clk_rise;
  logic lat_rise;

  logic [SYNC_STAGES:0][BUS_W-1:0] bus_q, bus_d;
  logic [BUS_W-1:0]                bus_s;
  logic [PIX_BITS-1:0]             rgb_s;
  logic [ROW_BITS-1:0]             addr_s;
  logic                            oe_s;

  logic [COLS-1:0][PIX_BITS-1:0] sr_q, sr_d;
  logic [COLS-1:0][PIX_BITS-1:0] dbuf_q, dbuf_d;
  logic [CNT_BITS-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [ROW_BITS-1:0]           row_q, row_d;
  logic [COL_BITS-1:0]           col_q, col_d;
  logic [LC_BITS-1:0]            lc_q, lc_d;
  dump_state_e                   state_q, state_d;
  logic len_err_q, len_err_d;
  logic overrun_q, overrun_d;
  logic lit_q, lit_d;
  logic valid_c, done_c;

  hub75_edge_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hub_clk),
    .rise (clk_rise)
  );

  hub75_edge_sync #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hub_lat),
    .rise (lat_rise)
  );

  // data bus gets one extra stage to match the edge detector delay
  assign bus_s  = bus_q[SYNC_STAGES];
  assign rgb_s  = bus_s[PIX_BITS-1:0];
  assign addr_s = bus_s[PIX_BITS +: ROW_BITS];
  assign oe_s   = bus_s[BUS_W-1];

  always_comb begin
    bus_d = {bus_q[SYNC_STAGES-1:0],
             {hub_oe, hub_addr, hub_rgb}};
    lit_d = ~oe_s;

    sr_d    = sr_q;
    cnt_inc = cnt_q;
    if (clk_rise) begin
      sr_d = {sr_q[COLS-2:0], rgb_s};
      if (cnt_q != CNT_MAX) cnt_inc = cnt_q + 1'b1;
    end
    cnt_d = cnt_inc;

    dbuf_d    = dbuf_q;
    row_d     = row_q;
    len_err_d = len_err_q;
    overrun_d = overrun_q;
    // a same-cycle shift is already folded into sr_d / cnt_inc
    if (lat_rise) begin
      cnt_d = '0;
      if (state_q == ST_IDLE) begin
        dbuf_d = sr_d;
        row_d  = addr_s;
        if (cnt_inc != CNT_FULL) len_err_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    state_d = state_q;
    col_d   = col_q;
    lc_d    = lc_q;
    valid_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lat_rise) begin
          state_d = ST_DUMP;
          col_d   = '0;
        end
      end
      ST_DUMP: begin
        valid_c = 1'b1;
        if (wr.wr_ready) begin
          col_d = col_q + 1'b1;
          if (col_q == COL_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        lc_d    = lc_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q     <= '0;
      sr_q      <= '0;
      dbuf_q    <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lc_q      <= '0;
      state_q   <= ST_IDLE;
      len_err_q <= 1'b0;
      overrun_q <= 1'b0;
      lit_q     <= 1'b0;
    end else begin
      bus_q     <= bus_d;
      sr_q      <= sr_d;
      dbuf_q    <= dbuf_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lc_q      <= lc_d;
      state_q   <= state_d;
      len_err_q <= len_err_d;
      overrun_q <= overrun_d;
      lit_q     <= lit_d;
    end
  end

  assign wr.wr_valid = valid_c;
  assign wr.wr_addr  = {row_q, col_q};
  assign wr.wr_data  = dbuf_q[col_q];
  assign line_done   = done_c;
  assign len_err     = len_err_q;
  assign overrun     = overrun_q;
  assign lit         = lit_q;
  assign line_count  = lc_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: full, short, long, stalled,
// overrun, reset-mid-dump and same-edge latch lines.
module tb_hub75_rx;
  import hub75_pkg::*;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hub_clk = 1'b0;
  logic        hub_lat = 1'b0;
  logic        hub_oe = 1'b1;
  logic [5:0]  hub_rgb = '0;
  logic [3:0]  hub_addr = '0;
  logic        line_done, len_err, overrun, lit;
  logic [15:0] line_count;

  int errors = 0;
  int checks = 0;

  hub75_rx_if wr_if();

  hub75_rx #(.SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .hub_clk    (hub_clk),
    .hub_rgb    (hub_rgb),
    .hub_addr   (hub_addr),
    .hub_lat    (hub_lat),
    .hub_oe     (hub_oe),
    .wr         (wr_if),
    .line_done  (line_done),
    .len_err    (len_err),
    .overrun    (overrun),
    .lit        (lit),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  logic [9:0] qa[$];
  logic [5:0] qd[$];
  int   done_cnt = 0;
  int   stab_err = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_a = '0;
  logic [5:0] prev_d = '0;

  // observe the write port mid-cycle
  always @(negedge clk) begin
    #1;
    if (wr_if.wr_valid && prev_stall &&
        (wr_if.wr_addr !== prev_a ||
         wr_if.wr_data !== prev_d))
      stab_err++;
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      qa.push_back(wr_if.wr_addr);
      qd.push_back(wr_if.wr_data);
    end
    if (line_done) done_cnt++;
    prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
    prev_a = wr_if.wr_addr;
    prev_d = wr_if.wr_data;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic shift_word(input logic [5:0] w);
    hub_clk = 1'b0;
    hub_rgb = w;
    repeat (2) @(negedge clk);
    hub_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic latch(input logic [3:0] a);
    hub_clk  = 1'b0;
    hub_addr = a;
    repeat (2) @(negedge clk);
    hub_lat = 1'b1;
    repeat (2) @(negedge clk);
    hub_lat = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hub_oe = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_if.wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", wr_if.wr_valid);
    end
    checks++;
    if ({wr_if.wr_addr, wr_if.wr_data} !== 16'h0) begin
      errors++;
      $display("FAIL rst_addr_data: got %h want 0",
               {wr_if.wr_addr, wr_if.wr_data});
    end
    checks++;
    if ({line_done, len_err, overrun, lit} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 0000",
               {line_done, len_err, overrun, lit});
    end
    checks++;
    if (line_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_count: got %h want 0", line_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lit();
    hub_oe = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (lit !== 1'b1) begin
      errors++;
      $display("FAIL lit_on: got %b want 1", lit);
    end
    hub_oe = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (lit !== 1'b0) begin
      errors++;
      $display("FAIL lit_off: got %b want 0", lit);
    end
  endtask

  task automatic test_full_line();
    int b;
    int lat;
    bit ok;
    do_reset();
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 64; k++) shift_word(6'(k));
    b = qa.size();
    hub_clk  = 1'b0;
    hub_addr = 4'd5;
    repeat (2) @(negedge clk);
    hub_lat = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (wr_if.wr_valid) begin
        lat = i;
        break;
      end
    end
    hub_lat = 1'b0;
    checks++;
    if (lat < 1 || lat > SS + 3) begin
      errors++;
      $display("FAIL full_latency: got %0d want 1..%0d", lat, SS + 3);
    end
    wait_done(200, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++;
      $display("FAIL full_done: got %0d pulses want 1", done_cnt);
    end
    checks++;
    if (qa.size() - b != 64) begin
      errors++;
      $display("FAIL full_count: got %0d want 64", qa.size() - b);
    end
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (b + c >= qa.size() ||
          qa[b+c] !== {4'd5, 6'(c)} ||
          qd[b+c] !== 6'(63 - c)) begin
        errors++;
        $display("FAIL full_col%0d: got %h/%h want %h/%h", c,
                 (b + c < qa.size()) ? qa[b+c] : 10'h3ff,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f,
                 {4'd5, 6'(c)}, 6'(63 - c));
      end
    end
    checks++;
    if (line_count !== 16'd1 || len_err !== 1'b0 ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_status: got lc=%0d le=%b ov=%b want 1/0/0",
               line_count, len_err, overrun);
    end
  endtask

  task automatic test_short_long();
    int b;
    bit ok;
    logic [5:0] exp;
    do_reset();
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 60; k++) shift_word(6'(k));
    b = qa.size();
    latch(4'd2);
    wait_done(200, ok);
    checks++;
    if (!ok || len_err !== 1'b1) begin
      errors++;
      $display("FAIL short_len_err: got %b want 1", len_err);
    end
    checks++;
    if (qa.size() - b != 64) begin
      errors++;
      $display("FAIL short_count: got %0d want 64", qa.size() - b);
    end
    for (int c = 0; c < 64; c++) begin
      exp = (c < 60) ? 6'(59 - c) : 6'd0;
      checks++;
      if (b + c >= qd.size() || qd[b+c] !== exp) begin
        errors++;
        $display("FAIL short_col%0d: got %h want %h", c,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f, exp);
      end
    end
    for (int k = 0; k < 70; k++) shift_word(6'(k % 64));
    b = qa.size();
    latch(4'd3);
    wait_done(200, ok);
    checks++;
    if (!ok || qa.size() - b != 64) begin
      errors++;
      $display("FAIL long_count: got %0d want 64", qa.size() - b);
    end
    for (int c = 0; c < 64; c++) begin
      exp = 6'((69 - c) % 64);
      checks++;
      if (b + c >= qd.size() || qd[b+c] !== exp ||
          qa[b+c] !== {4'd3, 6'(c)}) begin
        errors++;
        $display("FAIL long_col%0d: got %h want %h", c,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f, exp);
      end
    end
    checks++;
    if (line_count !== 16'd2) begin
      errors++;
      $display("FAIL long_lc: got %0d want 2", line_count);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int start;
    bit ok;
    logic [5:0] exp;
    do_reset();
    wr_if.wr_ready = 1'b0;
    for (int k = 0; k < 64; k++) shift_word(6'((k * 5 + 1) % 64));
    b = qa.size();
    start = done_cnt;
    latch(4'd9);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_if.wr_ready = ~wr_if.wr_ready;
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    wr_if.wr_ready = 1'b1;
    checks++;
    if (!ok || qa.size() - b != 64) begin
      errors++;
      $display("FAIL bp_count: got %0d want 64", qa.size() - b);
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes want 0", stab_err);
    end
    for (int c = 0; c < 64; c++) begin
      exp = 6'(((63 - c) * 5 + 1) % 64);
      checks++;
      if (b + c >= qa.size() || qd[b+c] !== exp ||
          qa[b+c] !== {4'd9, 6'(c)}) begin
        errors++;
        $display("FAIL bp_col%0d: got %h want %h", c,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f, exp);
      end
    end
  endtask

  task automatic test_overrun();
    int b;
    int start;
    bit ok;
    do_reset();
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 64; k++) shift_word(6'(63 - k));
    b = qa.size();
    start = done_cnt;
    latch(4'd7);
    for (int i = 0; i < 300; i++) begin
      if (qa.size() - b >= 10) break;
      @(negedge clk);
    end
    hub_lat = 1'b1;
    repeat (2) @(negedge clk);
    hub_lat = 1'b0;
    wait_done(200, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got %b want 1", overrun);
    end
    checks++;
    if (line_count !== 16'd1 || done_cnt - start != 1) begin
      errors++;
      $display("FAIL ovr_lines: got lc=%0d pulses=%0d want 1/1",
               line_count, done_cnt - start);
    end
    checks++;
    if (wr_if.wr_valid !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_idle: got v=%b le=%b want 0/0",
               wr_if.wr_valid, len_err);
    end
    checks++;
    if (qa.size() - b != 64) begin
      errors++;
      $display("FAIL ovr_count: got %0d want 64", qa.size() - b);
    end
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (b + c >= qa.size() || qd[b+c] !== 6'(c) ||
          qa[b+c] !== {4'd7, 6'(c)}) begin
        errors++;
        $display("FAIL ovr_col%0d: got %h want %h", c,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f, 6'(c));
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    logic [5:0] exp;
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 64; k++) shift_word(6'(k));
    b = qa.size();
    latch(4'd1);
    for (int i = 0; i < 300; i++) begin
      if (qa.size() - b >= 30) break;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wr_if.wr_valid !== 1'b0 ||
        {wr_if.wr_addr, wr_if.wr_data} !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst_bus: got v=%b %h want 0",
               wr_if.wr_valid, {wr_if.wr_addr, wr_if.wr_data});
    end
    checks++;
    if ({line_done, len_err, overrun, lit} !== 4'b0 ||
        line_count !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst_flags: got %b lc=%0d want 0",
               {line_done, len_err, overrun, lit}, line_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b = qa.size();
    repeat (10) @(negedge clk);
    checks++;
    if (wr_if.wr_valid !== 1'b0 || qa.size() != b) begin
      errors++;
      $display("FAIL mid_quiet: got v=%b writes=%0d want 0/0",
               wr_if.wr_valid, qa.size() - b);
    end
    for (int k = 0; k < 64; k++) shift_word(6'((k + 10) % 64));
    b = qa.size();
    latch(4'd15);
    wait_done(200, ok);
    checks++;
    if (!ok || qa.size() - b != 64) begin
      errors++;
      $display("FAIL mid_count: got %0d want 64", qa.size() - b);
    end
    for (int c = 0; c < 64; c++) begin
      exp = 6'((63 - c + 10) % 64);
      checks++;
      if (b + c >= qa.size() || qd[b+c] !== exp ||
          qa[b+c] !== {4'd15, 6'(c)}) begin
        errors++;
        $display("FAIL mid_col%0d: got %h want %h", c,
                 (b + c < qd.size()) ? qd[b+c] : 6'h3f, exp);
      end
    end
  endtask

  task automatic test_same_edge();
    int b;
    bit ok;
    do_reset();
    wr_if.wr_ready = 1'b1;
    for (int k = 0; k < 63; k++) shift_word(6'(k));
    b = qa.size();
    hub_clk  = 1'b0;
    hub_rgb  = 6'd63;
    hub_addr = 4'd4;
    repeat (2) @(negedge clk);
    hub_clk = 1'b1;
    hub_lat = 1'b1;
    repeat (2) @(negedge clk);
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || len_err !== 1'b0) begin
      errors++;
      $display("FAIL same_len_err: got %b want 0", len_err);
    end
    checks++;
    if (qa.size() - b != 64) begin
      errors++;
      $display("FAIL same_count: got %0d want 64", qa.size() - b);
    end
    checks++;
    if (qa.size() - b != 64 || qd[b] !== 6'd63 ||
        qa[b] !== {4'd4, 6'd0}) begin
      errors++;
      $display("FAIL same_col0: got %h want 3f",
               (b < qd.size()) ? qd[b] : 6'h0);
    end
    checks++;
    if (qa.size() - b != 64 || qd[b+1] !== 6'd62 ||
        qd[b+63] !== 6'd0) begin
      errors++;
      $display("FAIL same_tail: got %h/%h want 3e/00",
               (b + 1 < qd.size()) ? qd[b+1] : 6'h3f,
               (b + 63 < qd.size()) ? qd[b+63] : 6'h3f);
    end
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    test_reset();
    test_lit();
    test_full_line();
    test_short_long();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_same_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
